// File: rtl/timer_bus_ctrl_pkg.sv
// Shared types and default address map for the timer bus controller.
package timer_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    TGT_T0   = 3'd0,
    TGT_T1   = 3'd1,
    TGT_PEND = 3'd2,
    TGT_MASK = 3'd3,
    TGT_ERR  = 3'd4
  } tgt_e;

  localparam logic [31:0] T0_BASE_DEF  = 32'h0000_7F00;
  localparam logic [31:0] T1_BASE_DEF  = 32'h0000_7F10;
  localparam logic [31:0] CTL_BASE_DEF = 32'h0000_7F20;

endpackage

// File: rtl/timer_bus_ctrl_irq_pend.sv
// Rising-edge IRQ capture into a write-1-to-clear pending register with a mask.
module irq_pend #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic [N-1:0] irq_i,
  input  logic [N-1:0] clr_i,
  input  logic         mask_we_i,
  input  logic [N-1:0] mask_wd_i,
  output logic [N-1:0] pend_o,
  output logic [N-1:0] mask_o,
  output logic [N-1:0] int_o
);

  logic [N-1:0] irq_q, pend_q, pend_d, mask_q, mask_d;

  // Set is OR'd after the clear so a same-cycle edge is never lost.
  always_comb begin
    pend_d = (pend_q & ~clr_i) | (irq_i & ~irq_q);
    mask_d = mask_we_i ? mask_wd_i : mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      irq_q  <= '0;
      pend_q <= '0;
      mask_q <= '1;
    end else begin
      irq_q  <= irq_i;
      pend_q <= pend_d;
      mask_q <= mask_d;
    end
  end

  assign pend_o = pend_q;
  assign mask_o = mask_q;
  assign int_o  = pend_q & mask_q;

endmodule

// File: rtl/timer_bus_ctrl.sv
// CPU peripheral-port controller for two timers: fixed 3-cycle request/response
// with address decode and a maskable IRQ pending register driving HWInt.
module timer_bus_ctrl
  import timer_bus_ctrl_pkg::*;
#(
  parameter logic [31:0] T0_BASE  = T0_BASE_DEF,
  parameter logic [31:0] T1_BASE  = T1_BASE_DEF,
  parameter logic [31:0] CTL_BASE = CTL_BASE_DEF
) (
  input  logic        clk,
  input  logic        RST_I,
  input  logic        PrReq,
  input  logic        PrWE,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  output logic [31:0] PrRD,
  output logic        PrReady,
  output logic        PrErr,
  output logic        PrBusy,
  output logic [1:0]  Dev0Add,
  output logic [1:0]  Dev1Add,
  output logic        Dev0WE,
  output logic        Dev1WE,
  output logic [31:0] DevWD,
  input  logic [31:0] Dev0RD,
  input  logic [31:0] Dev1RD,
  input  logic        Dev0IRQ,
  input  logic        Dev1IRQ,
  output logic [5:0]  HWInt
);

  function automatic tgt_e decode(input logic [31:0] a);
    tgt_e t;
    t = TGT_ERR;
    if (a[1:0] == 2'b00) begin
      if (a[31:4] == T0_BASE[31:4] && a[3:2] != 2'd3)      t = TGT_T0;
      else if (a[31:4] == T1_BASE[31:4] && a[3:2] != 2'd3) t = TGT_T1;
      else if (a == CTL_BASE)                               t = TGT_PEND;
      else if (a == CTL_BASE + 32'd4)                       t = TGT_MASK;
    end
    return t;
  endfunction

  state_e      state_q, state_d;
  tgt_e        tgt_q;
  logic        we_q;
  logic [1:0]  add_q;
  logic [31:0] wd_q, rdata_q, rdata_d;
  logic [1:0]  pend, mask, irq_int, pend_clr;
  logic        access, mask_we;

  assign access = (state_q == S_ACCESS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (PrReq) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (!we_q) begin
      case (tgt_q)
        TGT_T0:   rdata_d = Dev0RD;
        TGT_T1:   rdata_d = Dev1RD;
        TGT_PEND: rdata_d = {30'b0, pend};
        TGT_MASK: rdata_d = {30'b0, mask};
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      tgt_q   <= TGT_ERR;
      we_q    <= 1'b0;
      add_q   <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && PrReq) begin
        tgt_q <= decode(PrAddr);
        we_q  <= PrWE;
        add_q <= PrAddr[3:2];
        wd_q  <= PrWD;
      end
      if (access) rdata_q <= rdata_d;
    end
  end

  assign pend_clr = (access && we_q && tgt_q == TGT_PEND) ? wd_q[1:0] : 2'b00;
  assign mask_we  = access && we_q && tgt_q == TGT_MASK;

  irq_pend #(.N(2)) u_irq_pend (
    .clk       (clk),
    .rst_i     (RST_I),
    .irq_i     ({Dev1IRQ, Dev0IRQ}),
    .clr_i     (pend_clr),
    .mask_we_i (mask_we),
    .mask_wd_i (wd_q[1:0]),
    .pend_o    (pend),
    .mask_o    (mask),
    .int_o     (irq_int)
  );

  // Reset gates the strobes so an aborted ACCESS never commits at the reset edge.
  assign Dev0WE  = access && we_q && tgt_q == TGT_T0 && !RST_I;
  assign Dev1WE  = access && we_q && tgt_q == TGT_T1 && !RST_I;
  assign Dev0Add = add_q;
  assign Dev1Add = add_q;
  assign DevWD   = wd_q;
  assign PrBusy  = (state_q != S_IDLE);
  assign PrReady = (state_q == S_RESP);
  assign PrErr   = PrReady && tgt_q == TGT_ERR;
  assign PrRD    = PrReady ? rdata_q : 32'h0;
  assign HWInt   = {4'b0, irq_int};

endmodule

// File: tb/tb_timer_bus_ctrl.sv
// Directed bench for timer_bus_ctrl: vector table of single transactions plus
// hand sequences for IRQ pending, set/clear collision and mid-access reset.
module tb_timer_bus_ctrl;

  logic        clk = 1'b0;
  logic        RST_I, PrReq, PrWE;
  logic [31:0] PrAddr, PrWD, PrRD, DevWD, Dev0RD, Dev1RD;
  logic        PrReady, PrErr, PrBusy, Dev0WE, Dev1WE, Dev0IRQ, Dev1IRQ;
  logic [1:0]  Dev0Add, Dev1Add;
  logic [5:0]  HWInt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_bus_ctrl dut (
    .clk(clk), .RST_I(RST_I), .PrReq(PrReq), .PrWE(PrWE), .PrAddr(PrAddr),
    .PrWD(PrWD), .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr), .PrBusy(PrBusy),
    .Dev0Add(Dev0Add), .Dev1Add(Dev1Add), .Dev0WE(Dev0WE), .Dev1WE(Dev1WE),
    .DevWD(DevWD), .Dev0RD(Dev0RD), .Dev1RD(Dev1RD), .Dev0IRQ(Dev0IRQ),
    .Dev1IRQ(Dev1IRQ), .HWInt(HWInt)
  );

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [1:0]  exp_add;
    logic        ew0;
    logic        ew1;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full request; irq1_acc raises Dev1IRQ during the ACCESS cycle.
  task automatic txn(input string nm, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input logic [1:0] exp_add, input logic ew0, input logic ew1,
                     input logic irq1_acc);
    @(negedge clk);
    PrReq = 1'b1; PrWE = we; PrAddr = addr; PrWD = wd; Dev0RD = d0; Dev1RD = d1;
    @(posedge clk); #1;
    PrReq = 1'b0; PrAddr = 32'hFFFF_FFFF; PrWD = 32'hFFFF_FFFF;
    if (irq1_acc) Dev1IRQ = 1'b1;
    chk({nm, " access busy"}, {31'b0, PrBusy}, 32'd1);
    chk({nm, " access ready"}, {31'b0, PrReady}, 32'd0);
    chk({nm, " access we0"}, {31'b0, Dev0WE}, {31'b0, ew0});
    chk({nm, " access we1"}, {31'b0, Dev1WE}, {31'b0, ew1});
    chk({nm, " dev0add"}, {30'b0, Dev0Add}, {30'b0, exp_add});
    chk({nm, " dev1add"}, {30'b0, Dev1Add}, {30'b0, exp_add});
    if (we) chk({nm, " devwd"}, DevWD, wd);
    @(posedge clk); #1;
    chk({nm, " ready"}, {31'b0, PrReady}, 32'd1);
    chk({nm, " err"}, {31'b0, PrErr}, {31'b0, exp_err});
    chk({nm, " rd"}, PrRD, exp_rd);
    chk({nm, " resp we"}, {30'b0, Dev1WE, Dev0WE}, 32'd0);
    Dev0RD = 32'hDEAD_0000; Dev1RD = 32'hDEAD_1111; #1;
    chk({nm, " rd hold"}, PrRD, exp_rd);
    @(posedge clk); #1;
    chk({nm, " idle ready"}, {31'b0, PrReady}, 32'd0);
    chk({nm, " idle busy"}, {31'b0, PrBusy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"wr t0 preset", 1'b1, 32'h7F04, 32'h10,   32'h0,    32'h0,    32'h0,    1'b0, 2'd1, 1'b1, 1'b0};
    vecs[1]  = '{"rd t1 count",  1'b0, 32'h7F18, 32'h0,    32'h0,    32'h1234, 32'h1234, 1'b0, 2'd2, 1'b0, 1'b0};
    vecs[2]  = '{"rd t0 ctrl",   1'b0, 32'h7F00, 32'h0,    32'hABCD, 32'h0,    32'hABCD, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{"wr 7f0c",      1'b1, 32'h7F0C, 32'h55,   32'h0,    32'h0,    32'h0,    1'b1, 2'd3, 1'b0, 1'b0};
    vecs[4]  = '{"rd 7f0c",      1'b0, 32'h7F0C, 32'h0,    32'h5555, 32'h6666, 32'h0,    1'b1, 2'd3, 1'b0, 1'b0};
    vecs[5]  = '{"wr 7f02",      1'b1, 32'h7F02, 32'h77,   32'h0,    32'h0,    32'h0,    1'b1, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{"rd 7f02",      1'b0, 32'h7F02, 32'h0,    32'h7777, 32'h0,    32'h0,    1'b1, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{"wr 8000",      1'b1, 32'h8000, 32'h99,   32'h0,    32'h0,    32'h0,    1'b1, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{"rd 8000",      1'b0, 32'h8000, 32'h0,    32'h8888, 32'h9999, 32'h0,    1'b1, 2'd0, 1'b0, 1'b0};
    vecs[9]  = '{"rd mask",      1'b0, 32'h7F24, 32'h0,    32'h0,    32'h0,    32'h3,    1'b0, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{"wr t1 preset", 1'b1, 32'h7F14, 32'h5,    32'h0,    32'h0,    32'h0,    1'b0, 2'd1, 1'b0, 1'b1};

    RST_I = 1'b1; PrReq = 1'b0; PrWE = 1'b0; PrAddr = '0; PrWD = '0;
    Dev0RD = '0; Dev1RD = '0; Dev0IRQ = 1'b0; Dev1IRQ = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {PrRD, DevWD} == '0 ? 32'd0 : 32'd1, 32'd0);
    chk("reset ctl", {26'b0, PrReady, PrErr, PrBusy, Dev0WE, Dev1WE, 1'b0}, 32'd0);
    chk("reset add", {28'b0, Dev0Add, Dev1Add}, 32'd0);
    chk("reset hwint", {26'b0, HWInt}, 32'd0);
    @(negedge clk); RST_I = 1'b0;

    for (int i = 0; i < 11; i++)
      txn(vecs[i].nm, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].d0, vecs[i].d1,
          vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_add, vecs[i].ew0, vecs[i].ew1, 1'b0);

    // IRQ0 one-cycle pulse latches and holds
    @(negedge clk); Dev0IRQ = 1'b1;
    @(posedge clk); #1;
    chk("irq0 hwint set", {26'b0, HWInt}, 32'h01);
    @(negedge clk); Dev0IRQ = 1'b0;
    @(posedge clk); #1;
    chk("irq0 hwint held", {26'b0, HWInt}, 32'h01);
    txn("w1c pend0", 1'b1, 32'h7F20, 32'h1, 0, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("hwint cleared", {26'b0, HWInt}, 32'h00);

    // IRQ1 pending but masked off
    @(negedge clk); Dev1IRQ = 1'b1;
    @(negedge clk); Dev1IRQ = 1'b0;
    #1 chk("irq1 hwint set", {26'b0, HWInt}, 32'h02);
    txn("wr mask 0", 1'b1, 32'h7F24, 32'h0, 0, 0, 0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("hwint masked", {26'b0, HWInt}, 32'h00);
    txn("rd pend masked", 1'b0, 32'h7F20, 32'h0, 0, 0, 32'h2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    txn("rd mask 0", 1'b0, 32'h7F24, 32'h0, 0, 0, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    // Clear bit1, then collide a new rise with another clear
    txn("w1c pend1", 1'b1, 32'h7F20, 32'h2, 0, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    txn("rd pend clr", 1'b0, 32'h7F20, 32'h0, 0, 0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    txn("w1c collide", 1'b1, 32'h7F20, 32'h2, 0, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    txn("rd pend set wins", 1'b0, 32'h7F20, 32'h0, 0, 0, 32'h2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); Dev1IRQ = 1'b0;

    // Reset during the ACCESS cycle of a timer0 write
    @(negedge clk);
    PrReq = 1'b1; PrWE = 1'b1; PrAddr = 32'h7F00; PrWD = 32'h7;
    @(posedge clk); #1;
    PrReq = 1'b0;
    RST_I = 1'b1; #1;
    chk("rst dev0we", {31'b0, Dev0WE}, 32'd0);
    @(posedge clk); #1;
    chk("rst ready", {31'b0, PrReady}, 32'd0);
    chk("rst busy", {31'b0, PrBusy}, 32'd0);
    chk("rst devwd", DevWD, 32'd0);
    @(posedge clk); #1;
    chk("rst ready2", {31'b0, PrReady}, 32'd0);
    @(negedge clk); RST_I = 1'b0;
    txn("post rst pend", 1'b0, 32'h7F20, 32'h0, 0, 0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    txn("post rst mask", 1'b0, 32'h7F24, 32'h0, 0, 0, 32'h3, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
